// File: rtl/uart_param_top.sv
// Parameterised UART transmitter/receiver with optional loopback and sticky status flags.
// Define UART_PARITY_EN to add an even-parity bit to every frame in both directions.
module uart_param_top #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned LOOPBACK     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  output logic              busy,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              rdy,
  input  logic              rdy_clr,
  output logic              overrun,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = 4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  tx_state_e         tx_state;
  logic [DATA_W-1:0] tx_shift;
  logic [BW-1:0]     tx_baud;
  logic [CW-1:0]     tx_bit;
  logic              tx_stop;

  rx_state_e         rx_state;
  logic [DATA_W-1:0] rx_shift;
  logic [BW-1:0]     rx_baud;
  logic [CW-1:0]     rx_bit;
  logic              sync1, sync2, sync_prev;
  logic              rx_src;

`ifdef UART_PARITY_EN
  logic tx_par;
  logic rx_par_bad;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_src = (LOOPBACK != 0) ? tx : rx;

  // Transmitter: tx and busy are registered so they change together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TxIdle;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_shift <= '0;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TxIdle: begin
          if (wr_en) begin
            tx_shift <= data_in;
`ifdef UART_PARITY_EN
            tx_par   <= ^data_in;
`endif
            tx_state <= TxStart;
            tx       <= 1'b0;
            busy     <= 1'b1;
            tx_baud  <= '0;
          end
        end
        TxStart: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= TxData;
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        TxData: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_stop <= 1'b0;
`ifdef UART_PARITY_EN
              tx       <= tx_par;
              tx_state <= TxParity;
`else
              tx       <= 1'b1;
              tx_state <= TxStop;
`endif
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx       <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TxParity: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud  <= '0;
            tx       <= 1'b1;
            tx_state <= TxStop;
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
`endif
        TxStop: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_stop == STOP_LAST) begin
              busy     <= 1'b0;
              tx_state <= TxIdle;
            end else begin
              tx_stop <= 1'b1;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        default: tx_state <= TxIdle;
      endcase
    end
  end

  // Receiver: start edge qualified at half a bit, then every sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RxIdle;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_prev  <= 1'b1;
      rx_shift   <= '0;
      rx_baud    <= '0;
      rx_bit     <= '0;
      data_out   <= '0;
      rdy        <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1     <= rx_src;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (rdy_clr) begin
        rdy       <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
`ifdef UART_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (rx_state)
        RxIdle: begin
          if (sync_prev && !sync2) begin
            rx_baud  <= '0;
            rx_state <= RxStart;
          end
        end
        RxStart: begin
          if (rx_baud == BAUD_HALF) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_state <= sync2 ? RxIdle : RxData;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        RxData: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {sync2, rx_shift[DATA_W-1:1]};
            if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= RxParity;
`else
              rx_state <= RxStop;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RxParity: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud    <= '0;
            rx_par_bad <= sync2 ^ (^rx_shift);
            rx_state   <= RxStop;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
`endif
        RxStop: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_state <= RxIdle;
            // A same-cycle rdy_clr frees the holding register for this frame.
            if (!rdy || rdy_clr) begin
              data_out <= rx_shift;
              rdy      <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            if (!sync2) frame_err <= 1'b1;
`ifdef UART_PARITY_EN
            if (rx_par_bad) parity_err <= 1'b1;
`endif
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param_top.sv
// Directed bench: loopback instance for TX/RX round trips, external-rx instance for
// framing, glitch and parity cases.
module tb_uart_param_top;

  localparam int CLKS = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, rdy_clr;
  logic [7:0] data_in;
  logic       busy, tx, rdy, overrun, frame_err, parity_err;
  logic [7:0] data_out;
  logic       rx_unused;

  logic       wr_en2, rdy_clr2, rx2;
  logic [7:0] data_in2;
  logic       busy2, tx2, rdy2, overrun2, fe2, pe2;
  logic [7:0] data_out2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_param_top #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .STOP_BITS(1), .LOOPBACK(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .busy(busy), .tx(tx),
    .rx(rx_unused), .data_out(data_out), .rdy(rdy), .rdy_clr(rdy_clr), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  uart_param_top #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .STOP_BITS(1), .LOOPBACK(0)) dut_ext (
    .clk(clk), .rst(rst), .data_in(data_in2), .wr_en(wr_en2), .busy(busy2), .tx(tx2),
    .rx(rx2), .data_out(data_out2), .rdy(rdy2), .rdy_clr(rdy_clr2), .overrun(overrun2),
    .frame_err(fe2), .parity_err(pe2)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i is the i-th bit on the wire (no parity)
    logic       par;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return rdy;
      1: return overrun;
      2: return !busy;
      3: return rdy2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, sig(sel)}, 32'd1);
  endtask

  function automatic logic [10:0] wire_seq(input vec_t v);
`ifdef UART_PARITY_EN
    return {1'b1, v.par, v.frame[8:1], 1'b0};
`else
    return {1'b0, v.frame};
`endif
  endfunction

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    tick();
    rdy_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    wait_for(2, 400, "idle before send");
    data_in = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // Checks every cycle of the frame; a stray wr_en mid-frame must not disturb it.
  task automatic send_check(input vec_t v);
    logic [10:0] seq;
    seq = wire_seq(v);
    send(v.data);
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < CLKS; c++) begin
        check($sformatf("tx %02h bit %0d cyc %0d {busy,tx}", v.data, i, c),
              {30'd0, busy, tx}, {30'd0, 1'b1, seq[i]});
        if (i == 3 && c == 5) begin
          wr_en   = 1'b1;
          data_in = ~v.data;
        end
        tick();
        wr_en = 1'b0;
      end
    end
    check($sformatf("tx %02h busy fall {busy,tx}", v.data), {30'd0, busy, tx}, 32'd1);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop);
    rx2 = 1'b0;
    repeat (CLKS) tick();
    for (int i = 0; i < 8; i++) begin
      rx2 = d[i];
      repeat (CLKS) tick();
    end
`ifdef UART_PARITY_EN
    rx2 = par;
    repeat (CLKS) tick();
`else
    if (par) rx2 = 1'b1;
`endif
    rx2 = stop;
    repeat (CLKS) tick();
    rx2 = 1'b1;
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    vecs[0] = '{data: 8'h41, frame: 10'b1010000010, par: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000, par: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, par: 1'b0};
    vecs[3] = '{data: 8'hA5, frame: 10'b1101001010, par: 1'b0};
    vecs[4] = '{data: 8'h80, frame: 10'b1100000000, par: 1'b1};
    vecs[5] = '{data: 8'h01, frame: 10'b1000000010, par: 1'b1};

    rst = 1'b1; wr_en = 1'b0; data_in = 8'h00; rdy_clr = 1'b0; rx_unused = 1'b1;
    wr_en2 = 1'b0; data_in2 = 8'h00; rdy_clr2 = 1'b0; rx2 = 1'b1;
    tick();
    tick();
    check("reset loopback {tx,busy,rdy,ovr,fe,pe}",
          {26'd0, tx, busy, rdy, overrun, frame_err, parity_err}, 32'h20);
    check("reset loopback data_out", {24'd0, data_out}, 32'h0);
    check("reset ext {tx,busy,rdy,ovr,fe,pe}", {26'd0, tx2, busy2, rdy2, overrun2, fe2, pe2},
          32'h20);
    check("reset ext data_out", {24'd0, data_out2}, 32'h0);
    rst = 1'b0;
    tick();

    // Round trips through the loopback path.
    for (int k = 0; k < 6; k++) begin
      pulse_clr();
      check("rdy cleared", {31'd0, rdy}, 32'd0);
      send_check(vecs[k]);
      wait_for(0, 60, "rdy after frame");
      check($sformatf("rx data %02h", vecs[k].data), {24'd0, data_out}, {24'd0, vecs[k].data});
      check("flags clean {ovr,fe,pe}", {29'd0, overrun, frame_err, parity_err}, 32'd0);
    end

    // Back-to-back: second frame accepted in the first busy=0 cycle.
    pulse_clr();
    send(8'h41);
    wait_for(0, 300, "rdy 41");
    pulse_clr();
    check("rdy_clr clears rdy", {31'd0, rdy}, 32'd0);
    wait_for(2, 40, "busy fall 41");
    data_in = 8'h55;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    check("b2b start {busy,tx}", {30'd0, busy, tx}, 32'h2);
    wait_for(0, 300, "rdy 55");
    check("b2b data", {24'd0, data_out}, 32'h55);

    // Overrun: second frame completes while rdy still set.
    pulse_clr();
    send(8'h12);
    wait_for(0, 300, "rdy 12");
    send(8'h34);
    wait_for(1, 400, "overrun 34");
    check("overrun keeps data", {24'd0, data_out}, 32'h12);
    check("overrun rdy", {31'd0, rdy}, 32'd1);
    pulse_clr();
    check("clr {rdy,ovr}", {30'd0, rdy, overrun}, 32'd0);

    // Reset mid-DATA with wr_en asserted during reset.
    send(8'hA5);
    repeat (3 * CLKS) tick();
    rst     = 1'b1;
    wr_en   = 1'b1;
    data_in = 8'hFF;
    tick();
    check("rst mid frame {tx,busy,rdy}", {29'd0, tx, busy, rdy}, 32'h4);
    rst   = 1'b0;
    wr_en = 1'b0;
    tick();
    check("wr_en during rst ignored busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      seen |= rdy;
      tick();
    end
    check("aborted frame never delivered", {31'd0, seen}, 32'd0);

    // External rx: stop bit low.
    rx_frame(8'hA5, 1'b0, 1'b0);
    wait_for(3, 40, "rdy ext A5");
    check("ext frame_err", {31'd0, fe2}, 32'd1);
    check("ext data A5", {24'd0, data_out2}, 32'hA5);
    rdy_clr2 = 1'b1;
    tick();
    rdy_clr2 = 1'b0;
    check("ext clr {rdy,fe}", {30'd0, rdy2, fe2}, 32'd0);

    // Short low glitch on idle line.
    rx2 = 1'b0;
    repeat (4) tick();
    rx2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      seen |= rdy2 | fe2;
      tick();
    end
    check("glitch ignored", {31'd0, seen}, 32'd0);
    rx_frame(8'h3C, 1'b0, 1'b1);
    wait_for(3, 40, "rdy ext 3C");
    check("ext data 3C", {24'd0, data_out2}, 32'h3C);
    check("ext 3C flags {ovr,fe,pe}", {29'd0, overrun2, fe2, pe2}, 32'd0);

`ifdef UART_PARITY_EN
    rdy_clr2 = 1'b1;
    tick();
    rdy_clr2 = 1'b0;
    rx_frame(8'h55, 1'b1, 1'b1);
    wait_for(3, 40, "rdy ext 55");
    check("ext parity_err", {31'd0, pe2}, 32'd1);
    check("ext data 55", {24'd0, data_out2}, 32'h55);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
